// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential +4 fetch, decode-resolved redirects with
// one-entry redirect buffer while fetch is blocked, saturating taken counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  output logic [31:0]      fetch_pc,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_kind,
  input  logic [31:0]      redirect_src_pc,
  input  logic [15:0]      imm16,
  input  logic [25:0]      index26,
  input  logic [31:0]      rs_val,
  output logic             redirect_pending,
  output logic             exc_addr_err,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [31:0]        pc_r, pc_s;
  logic [31:0]        pend_target_r, pend_target_s;
  logic               valid_r, valid_s;
  logic               pending_r, pending_s;
  logic               exc_r, exc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               inc_s;

  logic [31:0]        seq4_s;
  logic [31:0]        raw_target_s;
  logic [31:0]        target_s;
  logic               redir_s;
  logic               misalign_s;
  logic               advance_s;

  assign seq4_s     = redirect_src_pc + 32'd4;
  assign redir_s    = redirect_valid & (redirect_kind != 2'b11);
  assign target_s   = {raw_target_s[31:2], 2'b00};
  assign misalign_s = (raw_target_s[1:0] != 2'b00);
  assign advance_s  = valid_r & fetch_ready & ~stall;

  // Raw redirect target per control-transfer kind
  always_comb begin
    raw_target_s = 32'd0;
    case (redirect_kind)
      2'b00:   raw_target_s = seq4_s + {{14{imm16[15]}}, imm16, 2'b00};
      2'b01:   raw_target_s = {seq4_s[31:28], index26, 2'b00};
      2'b10:   raw_target_s = rs_val;
      default: raw_target_s = 32'd0;
    endcase
  end

  // Next-state, next-PC and buffered-redirect decision
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_target_s = pend_target_r;
    valid_s       = 1'b0;
    pending_s     = 1'b0;
    exc_s         = 1'b0;
    inc_s         = 1'b0;
    case (state_r)
      BOOT: begin
        state_s = RUN;
        valid_s = 1'b1;
      end
      RUN: begin
        valid_s = 1'b1;
        if (redir_s) begin
          exc_s = misalign_s;
          if (advance_s) begin
            pc_s  = target_s;
            inc_s = 1'b1;
          end else begin
            pend_target_s = target_s;
            pending_s     = 1'b1;
            state_s       = PEND;
          end
        end else if (advance_s) begin
          pc_s = pc_r + 32'd4;
        end else begin
          pc_s = pc_r;
        end
      end
      PEND: begin
        valid_s = 1'b1;
        // Latest redirect wins over the buffered one, even in its own cycle
        if (redir_s) begin
          exc_s         = misalign_s;
          pend_target_s = target_s;
        end else begin
          pend_target_s = pend_target_r;
        end
        if (advance_s) begin
          pc_s      = redir_s ? target_s : pend_target_r;
          inc_s     = 1'b1;
          pending_s = 1'b0;
          state_s   = RUN;
        end else begin
          pending_s = 1'b1;
        end
      end
      default: begin
        state_s = BOOT;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // Saturating taken-redirect counter
  always_comb begin
    if (inc_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      pend_target_r <= 32'd0;
      valid_r       <= 1'b0;
      pending_r     <= 1'b0;
      exc_r         <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pend_target_r <= pend_target_s;
      valid_r       <= valid_s;
      pending_r     <= pending_s;
      exc_r         <= exc_s;
      cnt_r         <= cnt_s;
    end
  end

  assign fetch_pc         = pc_r;
  assign fetch_valid      = valid_r;
  assign redirect_pending = pending_r;
  assign exc_addr_err     = exc_r;
  assign taken_cnt        = cnt_r;

endmodule
